// File: rtl/fft_peak_detect_if.sv
`default_nettype none
// =============================================================================
// Module   : fft_peak_detect_if
// Brief    : Stream and peak-result signals of the FFT peak detector.
// Revision : 1.0 - initial release
// =============================================================================
interface fft_peak_detect_if #(
  parameter int DATA_W    = 24,
  parameter int NFFT_LOG2 = 10,
  parameter int POW_W     = 2*DATA_W + 1
);
  logic [2*DATA_W-1:0]  s_axis_data_tdata;
  logic                 s_axis_data_tvalid;
  logic                 s_axis_data_tready;
  logic                 s_axis_data_tlast;
  logic [POW_W-1:0]     m_axis_pow_tdata;
  logic                 m_axis_pow_tvalid;
  logic                 m_axis_pow_tready;
  logic                 m_axis_pow_tlast;
  logic                 peak_valid;
  logic                 peak_ready;
  logic [NFFT_LOG2-1:0] peak_bin;
  logic [POW_W-1:0]     peak_pow;
  logic                 frame_len_err;
  logic                 peak_overrun;

  // master is the detector itself; slave is the surrounding fabric
  modport master (
    input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
           m_axis_pow_tready, peak_ready,
    output s_axis_data_tready, m_axis_pow_tdata, m_axis_pow_tvalid,
           m_axis_pow_tlast, peak_valid, peak_bin, peak_pow,
           frame_len_err, peak_overrun
  );

  modport slave (
    output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
           m_axis_pow_tready, peak_ready,
    input  s_axis_data_tready, m_axis_pow_tdata, m_axis_pow_tvalid,
           m_axis_pow_tlast, peak_valid, peak_bin, peak_pow,
           frame_len_err, peak_overrun
  );
endinterface
`default_nettype wire

// File: rtl/fft_peak_detect.sv
`default_nettype none
// =============================================================================
// Module   : fft_peak_detect
// Brief    : Per-bin power (re^2+im^2) stream with per-frame max-bin detection.
// Revision : 1.0 - initial release
// =============================================================================
module fft_peak_detect #(
  parameter int DATA_W    = 24,
  parameter int NFFT_LOG2 = 10
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fft_peak_detect_if.master bus
);
  localparam int POW_W = 2*DATA_W + 1;
  localparam logic [NFFT_LOG2-1:0] c_LAST_BIN = '1;

  logic                        w_en;
  logic signed [DATA_W-1:0]    w_re;
  logic signed [DATA_W-1:0]    w_im;
  logic signed [2*DATA_W-1:0]  w_re_x;
  logic signed [2*DATA_W-1:0]  w_im_x;
  logic signed [2*DATA_W-1:0]  w_re2;
  logic signed [2*DATA_W-1:0]  w_im2;
  logic [POW_W-1:0]            w_sum;
  logic                        w_s2_load;
  logic                        w_last_bin;
  logic                        w_frame_end;
  logic                        w_len_err;
  logic                        w_take;
  logic [POW_W-1:0]            w_new_pow;
  logic [NFFT_LOG2-1:0]        w_new_bin;
  logic                        w_res_free;

  logic                        r_s1_valid;
  logic                        r_s1_last;
  logic signed [2*DATA_W-1:0]  r_s1_re2;
  logic signed [2*DATA_W-1:0]  r_s1_im2;
  logic                        r_pow_valid;
  logic                        r_pow_last;
  logic [POW_W-1:0]            r_pow_data;
  logic [NFFT_LOG2-1:0]        r_bin_cnt;
  logic [POW_W-1:0]            r_max_pow;
  logic [NFFT_LOG2-1:0]        r_max_bin;
  logic                        r_peak_valid;
  logic [NFFT_LOG2-1:0]        r_peak_bin;
  logic [POW_W-1:0]            r_peak_pow;
  logic                        r_len_err;
  logic                        r_overrun;

  // One enable stalls the whole pipeline; the output register is the only skid point
  assign w_en = ~r_pow_valid | bus.m_axis_pow_tready;

  assign w_re   = bus.s_axis_data_tdata[DATA_W-1:0];
  assign w_im   = bus.s_axis_data_tdata[2*DATA_W-1:DATA_W];
  assign w_re_x = {{DATA_W{w_re[DATA_W-1]}}, w_re};
  assign w_im_x = {{DATA_W{w_im[DATA_W-1]}}, w_im};
  assign w_re2  = w_re_x * w_re_x;
  assign w_im2  = w_im_x * w_im_x;

  // Squares are never negative, so the sum is taken as unsigned with a carry bit
  assign w_sum = {1'b0, r_s1_re2} + {1'b0, r_s1_im2};

  assign w_s2_load   = w_en & r_s1_valid;
  assign w_last_bin  = (r_bin_cnt == c_LAST_BIN);
  assign w_frame_end = w_s2_load & (r_s1_last | w_last_bin);
  assign w_len_err   = w_s2_load & (r_s1_last ^ w_last_bin);

  // Strict compare keeps the earliest bin on ties
  assign w_take    = (r_bin_cnt == '0) | (w_sum > r_max_pow);
  assign w_new_pow = w_take ? w_sum : r_max_pow;
  assign w_new_bin = w_take ? r_bin_cnt : r_max_bin;

  assign w_res_free = ~r_peak_valid | bus.peak_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_re2    <= '0;
      r_s1_im2    <= '0;
      r_pow_valid <= 1'b0;
      r_pow_last  <= 1'b0;
      r_pow_data  <= '0;
    end else if (w_en) begin
      r_s1_valid  <= bus.s_axis_data_tvalid;
      r_s1_last   <= bus.s_axis_data_tlast;
      r_s1_re2    <= w_re2;
      r_s1_im2    <= w_im2;
      r_pow_valid <= r_s1_valid;
      r_pow_last  <= r_s1_last;
      r_pow_data  <= w_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin_cnt <= '0;
      r_max_pow <= '0;
      r_max_bin <= '0;
    end else if (w_s2_load) begin
      r_bin_cnt <= w_frame_end ? '0 : r_bin_cnt + 1'b1;
      r_max_pow <= w_new_pow;
      r_max_bin <= w_new_bin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak_valid <= 1'b0;
      r_peak_bin   <= '0;
      r_peak_pow   <= '0;
      r_len_err    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_len_err <= w_len_err;
      r_overrun <= w_frame_end & ~w_res_free;
      if (w_frame_end & w_res_free) begin
        r_peak_valid <= 1'b1;
        r_peak_bin   <= w_new_bin;
        r_peak_pow   <= w_new_pow;
      end else if (bus.peak_ready) begin
        r_peak_valid <= 1'b0;
      end
    end
  end

  assign bus.s_axis_data_tready = w_en;
  assign bus.m_axis_pow_tdata   = r_pow_data;
  assign bus.m_axis_pow_tvalid  = r_pow_valid;
  assign bus.m_axis_pow_tlast   = r_pow_last;
  assign bus.peak_valid         = r_peak_valid;
  assign bus.peak_bin           = r_peak_bin;
  assign bus.peak_pow           = r_peak_pow;
  assign bus.frame_len_err      = r_len_err;
  assign bus.peak_overrun       = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detect.sv
`default_nettype none
// =============================================================================
// Module   : tb_fft_peak_detect
// Brief    : Randomized scoreboard bench for fft_peak_detect.
// Revision : 1.0 - initial release
// =============================================================================
module tb_fft_peak_detect;
  localparam int DATA_W    = 24;
  localparam int NFFT_LOG2 = 10;
  localparam int POW_W     = 2*DATA_W + 1;
  localparam int NBINS     = 1 << NFFT_LOG2;

  typedef struct { longint pow; bit last; int cyc; } beat_t;
  typedef struct { int bin; longint pow; } peak_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_peak_detect_if #(.DATA_W(DATA_W), .NFFT_LOG2(NFFT_LOG2), .POW_W(POW_W)) bus ();
  fft_peak_detect #(.DATA_W(DATA_W), .NFFT_LOG2(NFFT_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t pow_q[$];
  peak_t peak_q[$];
  int    re_a [NBINS];
  int    im_a [NBINS];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    ferr_seen = 0;
  int    ovr_seen = 0;
  int    ferr_exp = 0;
  int    ovr_exp = 0;
  bit    lat_chk = 1'b0;
  beat_t mon_b;
  peak_t mon_p;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: power straight from the component values
  function automatic longint model_pow(input int i);
    return longint'(re_a[i]) * longint'(re_a[i]) + longint'(im_a[i]) * longint'(im_a[i]);
  endfunction

  function automatic peak_t expect_peak(input int len);
    peak_t p;
    p.bin = 0;
    p.pow = model_pow(0);
    for (int i = 1; i < len; i++)
      if (model_pow(i) > p.pow) begin
        p.bin = i;
        p.pow = model_pow(i);
      end
    return p;
  endfunction

  function automatic void fill_random(input int shift);
    for (int i = 0; i < NBINS; i++) begin
      re_a[i] = int'($urandom) >>> shift;
      im_a[i] = int'($urandom) >>> shift;
    end
  endfunction

  // Output-side monitor: every check happens mid-cycle, away from the clock edge
  always @(negedge clk) begin
    if (!rst) begin
      check("s_tready_vs_en", longint'(bus.s_axis_data_tready),
            longint'(!bus.m_axis_pow_tvalid || bus.m_axis_pow_tready));
      if (bus.frame_len_err) ferr_seen++;
      if (bus.peak_overrun) ovr_seen++;
      if (bus.m_axis_pow_tvalid && bus.m_axis_pow_tready) begin
        if (pow_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pow_unexpected: got beat %0d, scoreboard empty", bus.m_axis_pow_tdata);
        end else begin
          mon_b = pow_q.pop_front();
          check("pow_data", longint'(bus.m_axis_pow_tdata), mon_b.pow);
          check("pow_tlast", longint'(bus.m_axis_pow_tlast), longint'(mon_b.last));
          if (lat_chk) check("latency", longint'(cyc - mon_b.cyc), 2);
        end
      end
      if (bus.peak_valid && bus.peak_ready) begin
        if (peak_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL peak_unexpected: got bin %0d pow %0d, none expected", bus.peak_bin, bus.peak_pow);
        end else begin
          mon_p = peak_q.pop_front();
          check("peak_bin", longint'(bus.peak_bin), longint'(mon_p.bin));
          check("peak_pow", longint'(bus.peak_pow), mon_p.pow);
        end
      end
    end
  end

  task automatic send_frame(input int len, input bit with_last, input bit gaps, input bit pulse_ready);
    int    i;
    int    guard;
    beat_t b;
    i = 0;
    while (i < len) begin
      @(posedge clk);
      #1;
      if (gaps && ($urandom_range(0, 7) == 0)) begin
        bus.s_axis_data_tvalid = 1'b0;
        continue;
      end
      bus.s_axis_data_tdata  = {im_a[i][DATA_W-1:0], re_a[i][DATA_W-1:0]};
      bus.s_axis_data_tlast  = with_last && (i == len - 1);
      bus.s_axis_data_tvalid = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!bus.s_axis_data_tready) begin
        guard++;
        if (guard > 2000) begin
          $display("FAIL input_stall: tready stuck low at bin %0d", i);
          $fatal(1, "input stalled");
        end
        @(negedge clk);
      end
      b.pow  = model_pow(i);
      b.last = bus.s_axis_data_tlast;
      b.cyc  = cyc;
      pow_q.push_back(b);
      i++;
    end
    @(posedge clk);
    #1;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tlast  = 1'b0;
    if (pulse_ready) begin
      bus.peak_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.peak_ready = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 4000; k++) begin
      if (pow_q.size() == 0) break;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    check(name, longint'(pow_q.size()), 0);
    check({name, "_ferr"}, longint'(ferr_seen), longint'(ferr_exp));
    check({name, "_ovr"}, longint'(ovr_seen), longint'(ovr_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pow_tvalid"}, longint'(bus.m_axis_pow_tvalid), 0);
    check({tag, "_pow_tdata"}, longint'(bus.m_axis_pow_tdata), 0);
    check({tag, "_pow_tlast"}, longint'(bus.m_axis_pow_tlast), 0);
    check({tag, "_peak_valid"}, longint'(bus.peak_valid), 0);
    check({tag, "_peak_bin"}, longint'(bus.peak_bin), 0);
    check({tag, "_peak_pow"}, longint'(bus.peak_pow), 0);
    check({tag, "_pulses"}, longint'({bus.frame_len_err, bus.peak_overrun}), 0);
    check({tag, "_s_tready"}, longint'(bus.s_axis_data_tready), 1);
  endtask

  initial begin
    peak_t pa;
    peak_t pc;
    bus.s_axis_data_tdata  = '0;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tlast  = 1'b0;
    bus.m_axis_pow_tready  = 1'b1;
    bus.peak_ready         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("reset");

    // Single dominant bin, continuous stream, latency measured
    for (int i = 0; i < NBINS; i++) begin
      re_a[i] = 1;
      im_a[i] = 0;
    end
    re_a[300] = 3;
    im_a[300] = 4;
    lat_chk = 1'b1;
    send_frame(NBINS, 1'b1, 1'b0, 1'b0);
    peak_q.push_back(expect_peak(NBINS));
    wait_drain("frame_basic");

    // Most negative components on two bins: full-scale power and tie-break
    fill_random(10);
    re_a[10]  = -8388608;
    im_a[10]  = -8388608;
    re_a[700] = -8388608;
    im_a[700] = -8388608;
    send_frame(NBINS, 1'b1, 1'b0, 1'b0);
    peak_q.push_back(expect_peak(NBINS));
    wait_drain("frame_tie");
    lat_chk = 1'b0;

    // Backpressure: 5-cycle hold then random ready, random input gaps
    fill_random(8);
    fork
      send_frame(NBINS, 1'b1, 1'b1, 1'b0);
      begin
        repeat (300) @(posedge clk);
        #1 bus.m_axis_pow_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.m_axis_pow_tready = 1'b1;
        for (int k = 0; k < 200; k++) begin
          @(posedge clk);
          #1 bus.m_axis_pow_tready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1 bus.m_axis_pow_tready = 1'b1;
      end
    join
    peak_q.push_back(expect_peak(NBINS));
    wait_drain("frame_bp");

    // Short frame closed by tlast at bin 99, then a full frame
    fill_random(8);
    send_frame(100, 1'b1, 1'b1, 1'b0);
    peak_q.push_back(expect_peak(100));
    ferr_exp++;
    wait_drain("frame_short");
    fill_random(8);
    send_frame(NBINS, 1'b1, 1'b1, 1'b0);
    peak_q.push_back(expect_peak(NBINS));
    wait_drain("frame_after_short");

    // Full-length frame without tlast closes on its own
    fill_random(8);
    send_frame(NBINS, 1'b0, 1'b0, 1'b0);
    peak_q.push_back(expect_peak(NBINS));
    ferr_exp++;
    wait_drain("frame_nolast");

    // Result held across a second frame end; same-cycle consume loads the third
    bus.peak_ready = 1'b0;
    fill_random(8);
    send_frame(64, 1'b1, 1'b0, 1'b0);
    pa = expect_peak(64);
    peak_q.push_back(pa);
    ferr_exp++;
    wait_drain("ovr_first");
    fill_random(8);
    send_frame(64, 1'b1, 1'b0, 1'b0);
    ferr_exp++;
    ovr_exp++;
    wait_drain("ovr_second");
    check("ovr_held_bin", longint'(bus.peak_bin), longint'(pa.bin));
    check("ovr_held_pow", longint'(bus.peak_pow), pa.pow);
    fill_random(8);
    pc = expect_peak(64);
    peak_q.push_back(pc);
    send_frame(64, 1'b1, 1'b0, 1'b1);
    ferr_exp++;
    wait_drain("ovr_same_cycle");
    check("ovr_consumed_first", longint'(peak_q.size()), 1);
    check("ovr_new_valid", longint'(bus.peak_valid), 1);
    check("ovr_new_bin", longint'(bus.peak_bin), longint'(pc.bin));
    check("ovr_new_pow", longint'(bus.peak_pow), pc.pow);

    // Asynchronous reset mid-frame with beats and a peak result in flight
    fill_random(8);
    send_frame(501, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    pow_q.delete();
    peak_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    bus.peak_ready = 1'b1;
    check_reset_outputs("post_rst");
    fill_random(8);
    send_frame(NBINS, 1'b1, 1'b1, 1'b0);
    peak_q.push_back(expect_peak(NBINS));
    wait_drain("frame_after_rst");

    repeat (5) @(posedge clk);
    check("peak_queue_empty", longint'(peak_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
